// File: rtl/dds_command_sender.sv
// ============================================================================
// Module      : dds_command_sender
// Description : Host-side initiator for the DDS UART command protocol. Sends
//               tuning-word / enable / disable transactions and retries each
//               one until it is acknowledged or the attempt budget runs out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dds_command_sender #(
    parameter logic [7:0] CMD_BYTE0   = 8'h01,
    parameter logic [7:0] CMD_BYTE1   = 8'h02,
    parameter logic [7:0] CMD_BYTE2   = 8'h03,
    parameter logic [7:0] CMD_BYTE3   = 8'h04,
    parameter logic [7:0] CMD_ENABLE  = 8'h05,
    parameter logic [7:0] CMD_DISABLE = 8'h06,
    parameter logic [7:0] CMD_SET     = 8'h07,
    parameter logic [7:0] ACK_BYTE    = 8'hAA,
    parameter int         TIMEOUT     = 120000,
    parameter int         RETRIES     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        en_req,
    input  logic        dis_req,
    output logic        transmit,
    output logic [7:0]  tx_byte,
    input  logic        tx_busy,
    input  logic        received,
    input  logic [7:0]  rx_byte,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int c_tw = $clog2(TIMEOUT + 1);
    localparam int c_aw = $clog2(RETRIES + 1);

    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(TIMEOUT - 1);
    localparam logic [c_tw-1:0] c_tmo_max  = c_tw'(TIMEOUT);
    localparam logic [c_aw-1:0] c_retries  = c_aw'(RETRIES);

    localparam logic [1:0] c_seq_load = 2'd0;
    localparam logic [1:0] c_seq_en   = 2'd1;
    localparam logic [1:0] c_seq_dis  = 2'd2;

    localparam logic [2:0] c_txn_set = 3'd4;

    typedef enum logic [3:0] {
        c_idle      = 4'd0,
        c_send_cmd  = 4'd1,
        c_tx_guard  = 4'd2,
        c_tx_wait   = 4'd3,
        c_send_data = 4'd4,
        c_ack_wait  = 4'd5,
        c_next      = 4'd6,
        c_finish    = 4'd7,
        c_fail      = 4'd8
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [31:0]     r_word;
    logic [1:0]      r_seq;
    logic [2:0]      r_txn;
    logic            r_data_sent;
    logic [c_aw-1:0] r_attempt;
    logic [c_tw-1:0] r_tmo;
    logic            r_transmit;
    logic [7:0]      r_tx_byte;

    logic [7:0]      w_cmd_byte;
    logic [7:0]      w_data_byte;
    logic            w_has_data;
    logic            w_last_txn;
    logic            w_ack_ok;
    logic            w_nack;
    logic            w_timeout;
    logic [c_aw-1:0] w_attempt_inc;
    logic            w_retry_left;
    logic            w_send;
    logic [7:0]      w_send_byte;
    logic            w_attempt_fail;
    logic            w_busy;
    logic            w_done;
    logic            w_error;

    always_comb begin
        w_cmd_byte = CMD_DISABLE;
        case (r_seq)
            c_seq_load: begin
                case (r_txn)
                    3'd0:    w_cmd_byte = CMD_BYTE0;
                    3'd1:    w_cmd_byte = CMD_BYTE1;
                    3'd2:    w_cmd_byte = CMD_BYTE2;
                    3'd3:    w_cmd_byte = CMD_BYTE3;
                    default: w_cmd_byte = CMD_SET;
                endcase
            end
            c_seq_en: w_cmd_byte = CMD_ENABLE;
            default:  w_cmd_byte = CMD_DISABLE;
        endcase
    end

    always_comb begin
        w_data_byte = r_word[7:0];
        case (r_txn[1:0])
            2'd0:    w_data_byte = r_word[7:0];
            2'd1:    w_data_byte = r_word[15:8];
            2'd2:    w_data_byte = r_word[23:16];
            default: w_data_byte = r_word[31:24];
        endcase
    end

    // Only the four BYTEn transactions of a load carry a data byte; SET is last.
    assign w_has_data    = (r_seq == c_seq_load) && (r_txn < c_txn_set);
    assign w_last_txn    = (r_seq == c_seq_load) ? (r_txn == c_txn_set) : 1'b1;
    assign w_ack_ok      = received && (rx_byte == ACK_BYTE);
    assign w_nack        = received && (rx_byte != ACK_BYTE);
    assign w_timeout     = (r_tmo >= c_tmo_last);
    assign w_attempt_inc = r_attempt + c_aw'(1);
    assign w_retry_left  = (w_attempt_inc < c_retries);

    always_comb begin
        w_next_state   = r_state;
        w_send         = 1'b0;
        w_send_byte    = w_cmd_byte;
        w_attempt_fail = 1'b0;
        w_busy         = 1'b1;
        w_done         = 1'b0;
        w_error        = 1'b0;
        case (r_state)
            c_idle: begin
                w_busy = 1'b0;
                if (load || en_req || dis_req) begin
                    w_next_state = c_send_cmd;
                end
            end
            c_send_cmd: begin
                if (!tx_busy) begin
                    w_send       = 1'b1;
                    w_send_byte  = w_cmd_byte;
                    w_next_state = c_tx_guard;
                end
            end
            c_send_data: begin
                if (!tx_busy) begin
                    w_send       = 1'b1;
                    w_send_byte  = w_data_byte;
                    w_next_state = c_tx_guard;
                end
            end
            // Gives the UART one cycle to raise tx_busy after the strobe.
            c_tx_guard: w_next_state = c_tx_wait;
            c_tx_wait: begin
                if (!tx_busy) begin
                    if (!r_data_sent && w_has_data) begin
                        w_next_state = c_send_data;
                    end else begin
                        w_next_state = c_ack_wait;
                    end
                end
            end
            c_ack_wait: begin
                if (w_ack_ok) begin
                    w_next_state = c_next;
                end else if (w_nack || w_timeout) begin
                    w_attempt_fail = 1'b1;
                    w_next_state   = w_retry_left ? c_send_cmd : c_fail;
                end
            end
            c_next:   w_next_state = w_last_txn ? c_finish : c_send_cmd;
            c_finish: begin
                w_done       = 1'b1;
                w_next_state = c_idle;
            end
            c_fail: begin
                w_error      = 1'b1;
                w_next_state = c_idle;
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_idle;
            r_word      <= 32'd0;
            r_seq       <= c_seq_load;
            r_txn       <= 3'd0;
            r_data_sent <= 1'b0;
            r_attempt   <= '0;
            r_tmo       <= '0;
            r_transmit  <= 1'b0;
            r_tx_byte   <= 8'd0;
        end else begin
            r_state    <= w_next_state;
            r_transmit <= w_send;
            if (w_send) begin
                r_tx_byte <= w_send_byte;
            end

            if (r_state == c_idle) begin
                r_txn     <= 3'd0;
                r_attempt <= '0;
                if (load) begin
                    r_seq  <= c_seq_load;
                    r_word <= word;
                end else if (en_req) begin
                    r_seq <= c_seq_en;
                end else if (dis_req) begin
                    r_seq <= c_seq_dis;
                end
            end

            if (w_send) begin
                r_data_sent <= (r_state == c_send_data);
            end

            // Cleared whenever outside ACK_WAIT, so every entry starts at zero.
            if (r_state != c_ack_wait) begin
                r_tmo <= '0;
            end else if (r_tmo != c_tmo_max) begin
                r_tmo <= r_tmo + c_tw'(1);
            end

            if (w_attempt_fail) begin
                r_attempt <= w_attempt_inc;
            end

            if (r_state == c_next) begin
                r_attempt <= '0;
                if (!w_last_txn) begin
                    r_txn <= r_txn + 3'd1;
                end
            end
        end
    end

    assign transmit = r_transmit;
    assign tx_byte  = r_tx_byte;
    assign busy     = w_busy;
    assign done     = w_done;
    assign error    = w_error;

endmodule

`default_nettype wire

// File: tb/tb_dds_command_sender.sv
// ============================================================================
// Module      : tb_dds_command_sender
// Description : Directed self-checking bench for dds_command_sender with a
//               UART TX busy model and an ACK responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dds_command_sender;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        load     = 1'b0;
    logic [31:0] word     = 32'd0;
    logic        en_req   = 1'b0;
    logic        dis_req  = 1'b0;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        tx_busy;
    logic        received = 1'b0;
    logic [7:0]  rx_byte  = 8'd0;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dds_command_sender #(
        .TIMEOUT (50),
        .RETRIES (3)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .word     (word),
        .en_req   (en_req),
        .dis_req  (dis_req),
        .transmit (transmit),
        .tx_byte  (tx_byte),
        .tx_busy  (tx_busy),
        .received (received),
        .rx_byte  (rx_byte),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    // UART TX model: busy for busy_len cycles after each strobe.
    int busy_len = 3;
    int busy_cnt = 0;
    always @(posedge clk) begin
        if (rst)                busy_cnt <= 0;
        else if (transmit)      busy_cnt <= busy_len;
        else if (busy_cnt > 0)  busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    // Output monitor.
    int         cyc = 0;
    logic [7:0] tx_log[$];
    int         tx_time[$];
    int         done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int         dbl_cnt = 0, unstable_cnt = 0, busy_strobe_cnt = 0;
    logic       prev_tx = 1'b0;
    logic [7:0] prev_byte = 8'd0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (transmit) begin
            tx_log.push_back(tx_byte);
            tx_time.push_back(cyc);
        end
        if (done)               done_cnt <= done_cnt + 1;
        if (error)              err_cnt <= err_cnt + 1;
        if (done && error)      both_cnt <= both_cnt + 1;
        if (transmit && prev_tx) dbl_cnt <= dbl_cnt + 1;
        if (transmit && tx_busy) busy_strobe_cnt <= busy_strobe_cnt + 1;
        if (tx_busy && (tx_byte !== prev_byte)) unstable_cnt <= unstable_cnt + 1;
        prev_tx   <= transmit;
        prev_byte <= tx_byte;
    end

    // Responder: replies 5 cycles after the last byte of a transaction leaves TX.
    logic [7:0] drop_cmd   = 8'd0;
    logic [7:0] bad_cmd    = 8'd0;
    int         bad_budget = 0;
    int         bad_used   = 0;
    int         ack_cnt    = 0;
    initial begin : responder
        logic [7:0] last_cmd;
        logic [7:0] cmd;
        bit         expect_data;
        bit         eot;
        expect_data = 1'b0;
        last_cmd    = 8'd0;
        forever begin
            @(negedge clk);
            if (rst) begin
                expect_data = 1'b0;
            end else if (transmit) begin
                eot = 1'b1;
                cmd = tx_byte;
                if (expect_data) begin
                    cmd         = last_cmd;
                    expect_data = 1'b0;
                end else if (tx_byte >= 8'h01 && tx_byte <= 8'h04) begin
                    expect_data = 1'b1;
                    last_cmd    = tx_byte;
                    eot         = 1'b0;
                end
                if (eot && cmd != drop_cmd) begin
                    @(negedge clk);
                    while (tx_busy) @(negedge clk);
                    repeat (5) @(negedge clk);
                    if (cmd == bad_cmd && bad_used < bad_budget) begin
                        rx_byte  = 8'h55;
                        bad_used = bad_used + 1;
                    end else begin
                        rx_byte = 8'hAA;
                        ack_cnt = ack_cnt + 1;
                    end
                    received = 1'b1;
                    @(negedge clk);
                    received = 1'b0;
                end
            end
        end
    end

    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input bit l, input bit e, input bit d);
        load    = l;
        en_req  = e;
        dis_req = d;
        @(negedge clk);
        load    = 1'b0;
        en_req  = 1'b0;
        dis_req = 1'b0;
    endtask

    task automatic wait_end(input int base, input string tag);
        int n;
        n = 0;
        while ((done_cnt + err_cnt) == base && n < 3000) begin
            @(negedge clk);
            n = n + 1;
        end
        chk({tag, "_terminated"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_log(input string tag, input int start);
        logic [31:0] got;
        chk({tag, "_len"}, 32'(tx_log.size() - start), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (start + i < tx_log.size()) ? 32'(tx_log[start + i]) : 32'h1FF;
            chk($sformatf("%s_byte%0d", tag, i), got, 32'(exp_q[i]));
        end
    endtask

    initial begin : main
        int start, s_done, s_err, s_ack, s_dbl, s_unst, s_bstr, gap, n;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_transmit", 32'(transmit), 32'd0);
        chk("rst_tx_byte",  32'(tx_byte),  32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_error",    32'(error),    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: full load sequence.
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt; s_ack = ack_cnt;
        word = 32'h12345678;
        req(1'b1, 1'b0, 1'b0);
        chk("t1_busy_after_accept", 32'(busy), 32'd1);
        wait_end(s_done + s_err, "t1");
        chk("t1_busy_after_done", 32'(busy), 32'd0);
        exp_q = '{8'h01, 8'h78, 8'h02, 8'h56, 8'h03, 8'h34, 8'h04, 8'h12, 8'h07};
        check_log("t1", start);
        chk("t1_done_pulses", 32'(done_cnt - s_done), 32'd1);
        chk("t1_error_pulses", 32'(err_cnt - s_err), 32'd0);
        chk("t1_acks", 32'(ack_cnt - s_ack), 32'd5);

        // 2a: enable.
        repeat (3) @(negedge clk);
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        req(1'b0, 1'b1, 1'b0);
        wait_end(s_done + s_err, "t2en");
        exp_q = '{8'h05};
        check_log("t2en", start);
        chk("t2en_done", 32'(done_cnt - s_done), 32'd1);

        // 2b: disable.
        repeat (3) @(negedge clk);
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        req(1'b0, 1'b0, 1'b1);
        wait_end(s_done + s_err, "t2dis");
        exp_q = '{8'h06};
        check_log("t2dis", start);
        chk("t2dis_done", 32'(done_cnt - s_done), 32'd1);

        // 2c: simultaneous requests, plus a request while busy that must be dropped.
        repeat (3) @(negedge clk);
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        word = 32'hCAFEBABE;
        req(1'b1, 1'b1, 1'b1);
        word = 32'h0;
        repeat (10) @(negedge clk);
        req(1'b0, 1'b1, 1'b0);
        wait_end(s_done + s_err, "t2pri");
        repeat (40) @(negedge clk);
        exp_q = '{8'h01, 8'hBE, 8'h02, 8'hBA, 8'h03, 8'hFE, 8'h04, 8'hCA, 8'h07};
        check_log("t2pri", start);
        chk("t2pri_done", 32'(done_cnt - s_done), 32'd1);

        // 3: BYTE2 never acknowledged.
        drop_cmd = 8'h03;
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        word = 32'h12345678;
        req(1'b1, 1'b0, 1'b0);
        wait_end(s_done + s_err, "t3");
        chk("t3_busy_after_error", 32'(busy), 32'd0);
        exp_q = '{8'h01, 8'h78, 8'h02, 8'h56, 8'h03, 8'h34, 8'h03, 8'h34, 8'h03, 8'h34};
        check_log("t3", start);
        chk("t3_error_pulses", 32'(err_cnt - s_err), 32'd1);
        chk("t3_done_pulses", 32'(done_cnt - s_done), 32'd0);
        gap = (tx_log.size() >= start + 10) ? tx_time[start + 6] - tx_time[start + 4] : 0;
        chk("t3_retry_gap1", 32'(gap >= 55 && gap <= 70), 32'd1);
        gap = (tx_log.size() >= start + 10) ? tx_time[start + 8] - tx_time[start + 6] : 0;
        chk("t3_retry_gap2", 32'(gap >= 55 && gap <= 70), 32'd1);
        drop_cmd = 8'h00;

        // 4: one wrong reply to BYTE1.
        repeat (3) @(negedge clk);
        bad_cmd = 8'h02;
        bad_budget = bad_used + 1;
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        req(1'b1, 1'b0, 1'b0);
        wait_end(s_done + s_err, "t4");
        exp_q = '{8'h01, 8'h78, 8'h02, 8'h56, 8'h02, 8'h56, 8'h03, 8'h34, 8'h04, 8'h12, 8'h07};
        check_log("t4", start);
        chk("t4_done_pulses", 32'(done_cnt - s_done), 32'd1);
        chk("t4_error_pulses", 32'(err_cnt - s_err), 32'd0);
        bad_cmd = 8'h00;

        // 5: slow UART.
        repeat (3) @(negedge clk);
        busy_len = 20;
        s_dbl = dbl_cnt; s_unst = unstable_cnt; s_bstr = busy_strobe_cnt;
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        word = 32'h0F1E2D3C;
        req(1'b1, 1'b0, 1'b0);
        wait_end(s_done + s_err, "t5");
        exp_q = '{8'h01, 8'h3C, 8'h02, 8'h2D, 8'h03, 8'h1E, 8'h04, 8'h0F, 8'h07};
        check_log("t5", start);
        chk("t5_done_pulses", 32'(done_cnt - s_done), 32'd1);
        chk("t5_strobe_while_busy", 32'(busy_strobe_cnt - s_bstr), 32'd0);
        chk("t5_tx_byte_unstable", 32'(unstable_cnt - s_unst), 32'd0);
        chk("t5_double_strobe", 32'(dbl_cnt - s_dbl), 32'd0);
        busy_len = 3;

        // 6: reset while waiting for the BYTE1 ACK.
        repeat (25) @(negedge clk);
        drop_cmd = 8'h02;
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        word = 32'h12345678;
        req(1'b1, 1'b0, 1'b0);
        n = 0;
        while (tx_log.size() < start + 4 && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
        chk("t6_reached_byte1", 32'(n < 500), 32'd1);
        repeat (15) @(negedge clk);
        chk("t6_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_transmit", 32'(transmit), 32'd0);
        chk("t6_rst_tx_byte",  32'(tx_byte),  32'd0);
        chk("t6_rst_busy",     32'(busy),     32'd0);
        chk("t6_rst_done",     32'(done),     32'd0);
        chk("t6_rst_error",    32'(error),    32'd0);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt - s_done), 32'd0);
        chk("t6_no_error", 32'(err_cnt - s_err), 32'd0);
        chk("t6_no_resend", 32'(tx_log.size() - start), 32'd4);
        drop_cmd = 8'h00;
        start = tx_log.size(); s_done = done_cnt; s_err = err_cnt;
        word = 32'hA5A5A5A5;
        req(1'b1, 1'b0, 1'b0);
        wait_end(s_done + s_err, "t6b");
        exp_q = '{8'h01, 8'hA5, 8'h02, 8'hA5, 8'h03, 8'hA5, 8'h04, 8'hA5, 8'h07};
        check_log("t6b", start);
        chk("t6b_done_pulses", 32'(done_cnt - s_done), 32'd1);
        chk("t6b_error_pulses", 32'(err_cnt - s_err), 32'd0);

        chk("done_and_error_together", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
